// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle processor control FSM: fetch/decode/exec/mem/writeback sequencing and retired-instruction counter.
// Optional macro MC_CTRL_ILLEGAL_TRAP_EN: illegal opcodes enter a sticky TRAP state and expose the illegal port.
module mc_ctrl_fsm #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic [1:0]       aluop,
  output logic             alusrc,
  output logic             memread,
  output logic             memwrite,
  output logic             regwrite,
  output logic             memtoreg,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             branch,
  output logic [2:0]       state,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  output logic             illegal,
`endif
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_R      = 3'd0,
    C_I      = 3'd1,
    C_LOAD   = 3'd2,
    C_STORE  = 3'd3,
    C_BRANCH = 3'd4,
    C_ILL    = 3'd5
  } class_t;

  state_t cur, nxt;
  class_t cls, dec_cls;
  logic   retire;

  always_comb begin
    dec_cls = C_ILL;
    case (opcode)
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_I;
      7'b1100011: dec_cls = C_BRANCH;
      default:    dec_cls = C_ILL;
    endcase
  end

  always_comb begin
    nxt      = cur;
    aluop    = 2'b00;
    alusrc   = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    memtoreg = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    case (cur)
      S_FETCH: begin
        memread = 1'b1;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          nxt     = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_cls == C_ILL) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          nxt = S_TRAP;
`else
          nxt = S_FETCH;
`endif
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls)
          C_LOAD, C_STORE: begin
            alusrc = 1'b1;
            nxt    = S_MEM;
          end
          C_BRANCH: begin
            aluop  = 2'b01;
            branch = 1'b1;
            nxt    = S_FETCH;
          end
          C_R: begin
            aluop = 2'b10;
            nxt   = S_WB;
          end
          C_I: begin
            aluop  = 2'b10;
            alusrc = 1'b1;
            nxt    = S_WB;
          end
          default: nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        memread  = (cls == C_LOAD);
        memwrite = (cls == C_STORE);
        if (mem_ready) nxt = (cls == C_LOAD) ? S_WB : S_FETCH;
      end
      S_WB: begin
        regwrite = 1'b1;
        memtoreg = (cls == C_LOAD);
        nxt      = S_FETCH;
      end
      S_TRAP: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        nxt = S_TRAP;
`else
        nxt = S_FETCH;
`endif
      end
      default: nxt = S_FETCH;
    endcase
  end

  // Only completions out of EXEC/MEM/WB retire; the illegal-NOP return from DECODE does not.
  assign retire = (nxt == S_FETCH) && ((cur == S_EXEC) || (cur == S_MEM) || (cur == S_WB));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur     <= S_FETCH;
      cls     <= C_R;
      instret <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE) cls <= dec_cls;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                                     illegal <= 1'b0;
    else if ((cur == S_DECODE) && (nxt == S_TRAP)) illegal <= 1'b1;
  end
`endif

  assign state = cur;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: builds expected per-cycle traces from instruction-level rules.
module tb_mc_ctrl_fsm;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [6:0]       opcode = '0;
  logic             mem_ready = 1'b0;
  logic [1:0]       aluop;
  logic             alusrc, memread, memwrite, regwrite, memtoreg, irwrite, pcwrite, branch;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic             illegal;
`endif

  mc_ctrl_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .aluop(aluop), .alusrc(alusrc), .memread(memread), .memwrite(memwrite),
    .regwrite(regwrite), .memtoreg(memtoreg), .irwrite(irwrite), .pcwrite(pcwrite),
    .branch(branch), .state(state),
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    .illegal(illegal),
`endif
    .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]       st;
    logic [9:0]       ctrl;  // {aluop,alusrc,memread,memwrite,regwrite,memtoreg,irwrite,pcwrite,branch}
    logic             mr;
    logic [6:0]       op;
    logic [CNT_W-1:0] ir;
  } cyc_t;

  cyc_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cnt = 0;  // model retired count (mod 2^CNT_W applied on compare)

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BR = 7'b1100011;

  function automatic int kind(input logic [6:0] op);
    case (op)
      OP_R:     return 0;
      OP_I:     return 1;
      OP_LOAD:  return 2;
      OP_STORE: return 3;
      OP_BR:    return 4;
      default:  return 5;
    endcase
  endfunction

  function automatic logic [9:0] dut_ctrl();
    return {aluop, alusrc, memread, memwrite, regwrite, memtoreg, irwrite, pcwrite, branch};
  endfunction

  function automatic cyc_t blank(input logic [2:0] st, input logic [9:0] ctrl);
    cyc_t c;
    c.st   = st;
    c.ctrl = ctrl;
    c.mr   = 1'($urandom);
    c.op   = 7'($urandom);
    c.ir   = CNT_W'(cnt);
    return c;
  endfunction

  // Expected trace of one instruction: fw fetch wait cycles, mw memory wait cycles.
  task automatic plan(input logic [6:0] op, input int unsigned fw, input int unsigned mw);
    cyc_t c;
    int   k;
    k = kind(op);
    for (int unsigned i = 0; i < fw; i++) begin
      c = blank(3'd0, 10'b00_0_1_0_0_0_0_0_0); c.mr = 1'b0; q.push_back(c);
    end
    c = blank(3'd0, 10'b00_0_1_0_0_0_1_1_0); c.mr = 1'b1; q.push_back(c);
    c = blank(3'd1, '0); c.op = op; q.push_back(c);
    if (k == 5) return;
    case (k)
      0:       c = blank(3'd2, 10'b10_0_0_0_0_0_0_0_0);
      1:       c = blank(3'd2, 10'b10_1_0_0_0_0_0_0_0);
      2, 3:    c = blank(3'd2, 10'b00_1_0_0_0_0_0_0_0);
      default: c = blank(3'd2, 10'b01_0_0_0_0_0_0_0_1);
    endcase
    q.push_back(c);
    if (k == 2 || k == 3) begin
      for (int unsigned i = 0; i <= mw; i++) begin
        c = blank(3'd3, (k == 2) ? 10'b00_0_1_0_0_0_0_0_0 : 10'b00_0_0_1_0_0_0_0_0);
        c.mr = (i == mw);
        q.push_back(c);
      end
    end
    if (k == 0 || k == 1 || k == 2) begin
      c = blank(3'd4, (k == 2) ? 10'b00_0_0_0_1_1_0_0_0 : 10'b00_0_0_0_1_0_0_0_0);
      q.push_back(c);
    end
    cnt++;
  endtask

  task automatic drive(input logic rn, input logic mr, input logic [6:0] op);
    @(posedge clk);
    #1;
    rst_n = rn; mem_ready = mr; opcode = op;
    #1;
  endtask

  function automatic logic [6:0] rand_illegal();
    logic [6:0] op;
    do op = 7'($urandom); while (kind(op) != 5);
    return op;
  endfunction

  task automatic test_reset();
    drive(1'b0, 1'b1, 7'($urandom));
    drive(1'b0, 1'b1, 7'($urandom));
    drive(1'b1, 1'b0, 7'($urandom));
    cnt = 0;
    n_cmp++;
    if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++;
    if (dut_ctrl() !== 10'b00_0_1_0_0_0_0_0_0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want %b", dut_ctrl(), 10'b00_0_1_0_0_0_0_0_0);
    end
    n_cmp++;
    if (instret !== '0) begin n_bad++; $display("FAIL reset_instret: got %0d want 0", instret); end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    n_cmp++;
    if (illegal !== 1'b0) begin n_bad++; $display("FAIL reset_illegal: got %b want 0", illegal); end
`endif
  endtask

  task automatic test_instr_stream();
    cyc_t c;
    int   k;
    plan(OP_R, 0, 0);
    plan(OP_LOAD, 0, 3);
    plan(OP_STORE, 1, 2);
    plan(OP_BR, 0, 0);
    plan(OP_I, 2, 0);
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
    plan(7'b1111111, 0, 0);
`endif
    for (int i = 0; i < 30; i++) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      k = $urandom_range(4, 0);
`else
      k = $urandom_range(5, 0);
`endif
      case (k)
        0:       plan(OP_R, $urandom_range(3, 0), 0);
        1:       plan(OP_I, $urandom_range(3, 0), 0);
        2:       plan(OP_LOAD, $urandom_range(3, 0), $urandom_range(3, 0));
        3:       plan(OP_STORE, $urandom_range(3, 0), $urandom_range(3, 0));
        4:       plan(OP_BR, $urandom_range(3, 0), 0);
        default: plan(rand_illegal(), $urandom_range(3, 0), 0);
      endcase
    end
    while (q.size() > 0) begin
      c = q.pop_front();
      drive(1'b1, c.mr, c.op);
      n_cmp++;
      if (state !== c.st) begin n_bad++; $display("FAIL stream_state: got %0d want %0d", state, c.st); end
      n_cmp++;
      if (dut_ctrl() !== c.ctrl) begin
        n_bad++; $display("FAIL stream_ctrl: state %0d got %b want %b", c.st, dut_ctrl(), c.ctrl);
      end
      n_cmp++;
      if (instret !== c.ir) begin n_bad++; $display("FAIL stream_instret: got %0d want %0d", instret, c.ir); end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      n_cmp++;
      if (illegal !== 1'b0) begin n_bad++; $display("FAIL stream_illegal: got %b want 0", illegal); end
`endif
    end
  endtask

  task automatic test_reset_mid_mem();
    cyc_t c;
    plan(OP_STORE, 0, 6);
    for (int i = 0; i < 4; i++) begin
      c = q.pop_front();
      drive(1'b1, c.mr, c.op);
    end
    n_cmp++;
    if (state !== 3'd3 || memwrite !== 1'b1) begin
      n_bad++; $display("FAIL midmem_pre: got state %0d memwrite %b want 3 1", state, memwrite);
    end
    drive(1'b0, 1'b0, 7'($urandom));
    drive(1'b1, 1'b0, 7'($urandom));
    q.delete();
    cnt = 0;
    n_cmp++;
    if (state !== 3'd0 || memwrite !== 1'b0 || memread !== 1'b1) begin
      n_bad++; $display("FAIL midmem_reset: got state %0d memwrite %b memread %b want 0 0 1", state, memwrite, memread);
    end
    n_cmp++;
    if (instret !== '0) begin n_bad++; $display("FAIL midmem_instret: got %0d want 0", instret); end
  endtask

  task automatic test_wrap();
    cyc_t c;
    for (int i = 0; i < 15; i++) plan(OP_R, 0, 0);
    while (q.size() > 0) begin c = q.pop_front(); drive(1'b1, c.mr, c.op); end
    drive(1'b1, 1'b0, 7'($urandom));
    n_cmp++;
    if (instret !== CNT_W'(15)) begin n_bad++; $display("FAIL wrap_full: got %0d want 15", instret); end
    plan(OP_BR, 0, 0);
    while (q.size() > 0) begin c = q.pop_front(); drive(1'b1, c.mr, c.op); end
    drive(1'b1, 1'b0, 7'($urandom));
    n_cmp++;
    if (instret !== '0 || CNT_W'(cnt) !== '0) begin
      n_bad++; $display("FAIL wrap_zero: got %0d want 0", instret);
    end
  endtask

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  task automatic test_trap();
    logic [CNT_W-1:0] before;
    plan(OP_R, 0, 0);
    while (q.size() > 0) begin cyc_t c; c = q.pop_front(); drive(1'b1, c.mr, c.op); end
    before = CNT_W'(cnt);
    drive(1'b1, 1'b1, 7'($urandom));
    drive(1'b1, 1'($urandom), 7'b1111111);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'($urandom), 7'($urandom));
      n_cmp++;
      if (state !== 3'd5 || illegal !== 1'b1 || dut_ctrl() !== '0 || instret !== before) begin
        n_bad++;
        $display("FAIL trap_hold: got state %0d illegal %b ctrl %b instret %0d want 5 1 0 %0d",
                 state, illegal, dut_ctrl(), instret, before);
      end
    end
    drive(1'b0, 1'b0, 7'($urandom));
    drive(1'b1, 1'b0, 7'($urandom));
    cnt = 0;
    n_cmp++;
    if (state !== 3'd0 || illegal !== 1'b0 || instret !== '0) begin
      n_bad++; $display("FAIL trap_reset: got state %0d illegal %b instret %0d want 0 0 0", state, illegal, instret);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_instr_stream();
    test_reset_mid_mem();
    test_wrap();
    test_instr_stream();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    test_trap();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
